wave_sequencer: RTL and testbench
=================================

WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 Parameter STEPS, default 8: number of program-table entries (power of two).
REQ-002 Parameter DWELL_W, default 16: width of per-step dwell count.
REQ-003 Parameter IDLE_FUNC, default 3'b000: func code driven when not running.
REQ-004 clk  input  1  rising-edge clock; sole clock of the block.
REQ-005 rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-006 wr_en  input  1  table write strobe.
REQ-007 wr_addr  input  log2(STEPS)  table entry index.
REQ-008 wr_func  input  3  func code for entry.
REQ-009 wr_dwell  input  DWELL_W  dwell for entry; the step lasts wr_dwell+1 cycles.
REQ-010 last_step  input  log2(STEPS)  index of final step; sampled at start.
REQ-011 loop  input  1  repeat program after last step; sampled at start.
REQ-012 start  input  1  one-cycle request to begin program.
REQ-013 stop  input  1  abort program.
REQ-014 pause  input  1  level; freezes dwell countdown while high.
REQ-015 func  output  3  registered func code for the waveform generator.
REQ-016 step_idx  output  log2(STEPS)  index of current step.
REQ-017 step_pulse  output  1  one-cycle strobe when a new step is entered.
REQ-018 busy  output  1  high in RUN or PAUSE.
REQ-019 done  output  1  one-cycle strobe on normal completion.

Function
REQ-020 FSM states SHALL be IDLE, RUN, PAUSE, DONE.
REQ-021 IDLE: start=1 and stop=0 -> RUN next cycle with step_idx=0, func=table[0].func, counter=table[0].dwell, step_pulse=1; last_step and loop latched.
REQ-022 RUN: counter decrements by 1 per cycle; when counter=0 the step ends.
REQ-023 Step end with step_idx<last_step -> step_idx+1, func and counter reloaded from that entry, step_pulse=1, same cycle boundary (no gap cycle).
REQ-024 Step end with step_idx=last_step and latched loop=1 -> step_idx=0, reload entry 0, step_pulse=1.
REQ-025 Step end with step_idx=last_step and latched loop=0 -> DONE; done=1 for that single cycle; func=IDLE_FUNC; then IDLE.
REQ-026 RUN with pause=1 -> PAUSE; counter, func, step_idx held; pause=0 -> RUN, countdown resumes from held value.
REQ-027 stop=1 in RUN or PAUSE -> IDLE next cycle, func=IDLE_FUNC, done NOT asserted.
REQ-028 Priority: stop > pause > step end; stop and start together in IDLE -> remain IDLE.
REQ-029 start while busy SHALL be ignored.
REQ-030 Table writes SHALL take effect only in IDLE; writes while busy or in DONE are discarded.
REQ-031 Counter SHALL be exactly DWELL_W bits; dwell=0 gives 1-cycle step; max dwell gives 2^DWELL_W cycles.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 rst=0: state=IDLE, func=IDLE_FUNC, step_idx=0, step_pulse=0, busy=0, done=0, counter=0, latched loop=0, last_step=0.
REQ-034 Table contents SHALL reset to func=IDLE_FUNC, dwell=0.
REQ-035 Reset mid-program SHALL abort without done.

Configuration
REQ-036 Macro WAVE_SEQ_LOOP_EN defined: loop input functional per REQ-024.
REQ-037 Macro undefined: loop input ignored, latched loop forced 0, program always single-shot.

Structure
REQ-038 Package wave_seq_pkg SHALL hold the state enum, func-code constants (000..110) and default STEPS/DWELL_W.
REQ-039 Table SHALL be a sub-module wave_seq_table (STEPS x (3+DWELL_W) register file, one write port, one async read port).

Verification
REQ-040 Program entries 0..2 = (001,3),(010,0),(101,1), last_step=2, loop=0, start -> func 001 for 4 cycles, 010 for 1, 101 for 2, done pulse, func=000.
REQ-041 Same program, loop=1 (macro defined), stop after 20 cycles -> func sequence repeats with period 7 cycles, stop gives func=000 next cycle, no done.
REQ-042 Entry 0=(011,9), pause high for 5 cycles starting at cycle 3 -> func 011 held 15 cycles total.
REQ-043 wr_en to entry 0 while busy -> next run uses original entry value.
REQ-044 rst=0 asserted in mid-step -> next cycle all outputs at reset values; table entries read back as (000,0).
REQ-045 Build without WAVE_SEQ_LOOP_EN, loop=1 -> single pass, done asserted once.

Source files
------------

// File: rtl/wave_seq_pkg.sv
`default_nettype none
// ============================================================================
// wave_seq_pkg : shared state encoding, func codes and defaults for wave_sequencer
// Rev 1.0
// ============================================================================
package wave_seq_pkg;

  localparam int DEF_STEPS   = 8;
  localparam int DEF_DWELL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam logic [2:0] FUNC_OFF     = 3'b000;
  localparam logic [2:0] FUNC_SINE    = 3'b001;
  localparam logic [2:0] FUNC_SQUARE  = 3'b010;
  localparam logic [2:0] FUNC_TRI     = 3'b011;
  localparam logic [2:0] FUNC_SAW_UP  = 3'b100;
  localparam logic [2:0] FUNC_SAW_DN  = 3'b101;
  localparam logic [2:0] FUNC_NOISE   = 3'b110;

endpackage
`default_nettype wire

// File: rtl/wave_seq_table.sv
`default_nettype none
// ============================================================================
// wave_seq_table : STEPS x (func, dwell) register file, one write port, async read
// Rev 1.0
// ============================================================================
module wave_seq_table
  import wave_seq_pkg::*;
#(
  parameter int         STEPS    = DEF_STEPS,
  parameter int         DWELL_W  = DEF_DWELL_W,
  parameter logic [2:0] RST_FUNC = FUNC_OFF,
  localparam int        AW       = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [2:0]         wfunc_i,
  input  logic [DWELL_W-1:0] wdwell_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [2:0]         rfunc_o,
  output logic [DWELL_W-1:0] rdwell_o
);

  logic [2:0]         func_q  [STEPS];
  logic [DWELL_W-1:0] dwell_q [STEPS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < STEPS; i++) begin
        func_q[i]  <= RST_FUNC;
        dwell_q[i] <= '0;
      end
    end else if (we_i) begin
      func_q[waddr_i]  <= wfunc_i;
      dwell_q[waddr_i] <= wdwell_i;
    end
  end

  assign rfunc_o  = func_q[raddr_i];
  assign rdwell_o = dwell_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/wave_sequencer.sv
`default_nettype none
// ============================================================================
// wave_sequencer : table-driven func-code step sequencer with dwell, pause, stop.
// Program looping is available only when WAVE_SEQ_LOOP_EN is defined. Rev 1.0
// ============================================================================
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter int         STEPS     = DEF_STEPS,
  parameter int         DWELL_W   = DEF_DWELL_W,
  parameter logic [2:0] IDLE_FUNC = FUNC_OFF,
  localparam int        AW        = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [2:0]         wr_func,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [AW-1:0]      last_step,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  output logic [2:0]         func,
  output logic [AW-1:0]      step_idx,
  output logic               step_pulse,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_PAUSE = ST_PAUSE;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]         state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW-1:0]      last_q, last_d;
  logic               loop_q, loop_d;
  logic [2:0]         func_q, func_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               loop_in;
  logic               tbl_we;
  logic [AW-1:0]      rd_addr;
  logic [2:0]         rd_func;
  logic [DWELL_W-1:0] rd_dwell;

`ifdef WAVE_SEQ_LOOP_EN
  assign loop_in = loop;
`else
  assign loop_in = loop & 1'b0;
`endif

  // The table is frozen for the whole program, including the DONE cycle.
  assign tbl_we = wr_en && (state_q == S_IDLE);

  // Entry needed at the next boundary: 0 on start or wrap, otherwise the successor.
  always_comb begin
    if ((state_q == S_IDLE) || (idx_q >= last_q)) begin
      rd_addr = '0;
    end else begin
      rd_addr = idx_q + 1'b1;
    end
  end

  wave_seq_table #(
    .STEPS    (STEPS),
    .DWELL_W  (DWELL_W),
    .RST_FUNC (IDLE_FUNC)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .we_i     (tbl_we),
    .waddr_i  (wr_addr),
    .wfunc_i  (wr_func),
    .wdwell_i (wr_dwell),
    .raddr_i  (rd_addr),
    .rfunc_o  (rd_func),
    .rdwell_o (rd_dwell)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    loop_d  = loop_q;
    func_d  = func_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_RUN;
          idx_d   = '0;
          func_d  = rd_func;
          cnt_d   = rd_dwell;
          pulse_d = 1'b1;
          last_d  = last_step;
          loop_d  = loop_in;
        end
      end
      S_RUN, S_PAUSE: begin
        // A released pause counts as a normal countdown cycle.
        if (stop) begin
          state_d = S_IDLE;
          func_d  = IDLE_FUNC;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (cnt_q != '0) begin
          state_d = S_RUN;
          cnt_d   = cnt_q - 1'b1;
        end else if ((idx_q < last_q) || loop_q) begin
          state_d = S_RUN;
          idx_d   = rd_addr;
          func_d  = rd_func;
          cnt_d   = rd_dwell;
          pulse_d = 1'b1;
        end else begin
          state_d = S_DONE;
          func_d  = IDLE_FUNC;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        func_d  = IDLE_FUNC;
      end
    endcase
  end

  assign busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      func_q  <= IDLE_FUNC;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      func_q  <= func_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign func       = func_q;
  assign step_idx   = idx_q;
  assign step_pulse = pulse_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_sequencer.sv
`default_nettype none
// ============================================================================
// tb_wave_sequencer : directed program scenarios plus random traffic vs. step model
// Rev 1.0
// ============================================================================
module tb_wave_sequencer;

  localparam int         STEPS   = 8;
  localparam int         DWELL_W = 4;
  localparam int         AW      = 3;
  localparam logic [2:0] IDLE_F  = 3'b000;
`ifdef WAVE_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               wr_en = 1'b0;
  logic [AW-1:0]      wr_addr = '0;
  logic [2:0]         wr_func = '0;
  logic [DWELL_W-1:0] wr_dwell = '0;
  logic [AW-1:0]      last_step = '0;
  logic               loop = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               pause = 1'b0;
  logic [2:0]         func;
  logic [AW-1:0]      step_idx;
  logic               step_pulse;
  logic               busy;
  logic               done;

  wave_sequencer #(
    .STEPS     (STEPS),
    .DWELL_W   (DWELL_W),
    .IDLE_FUNC (IDLE_F)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_func    (wr_func),
    .wr_dwell   (wr_dwell),
    .last_step  (last_step),
    .loop       (loop),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .func       (func),
    .step_idx   (step_idx),
    .step_pulse (step_pulse),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a program is a walk over table entries, each lasting
  // dwell+1 unpaused cycles; m_left counts the unpaused cycles still owed.
  logic [2:0]         m_tf [STEPS];
  logic [DWELL_W-1:0] m_td [STEPS];
  bit                 m_active, m_loop;
  int                 m_left, m_last;
  logic [2:0]         e_func;
  int                 e_idx;
  bit                 e_pulse, e_busy, e_done;

  task automatic m_enter(input int s);
    e_idx   = s;
    e_func  = m_tf[s];
    m_left  = int'(m_td[s]) + 1;
    e_pulse = 1'b1;
  endtask

  task automatic model_edge();
    bit was_idle, fin;
    if (!rst) begin
      for (int i = 0; i < STEPS; i++) begin
        m_tf[i] = IDLE_F;
        m_td[i] = '0;
      end
      m_active = 1'b0; m_loop = 1'b0; m_last = 0; m_left = 0;
      e_func = IDLE_F; e_idx = 0; e_pulse = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      was_idle = !m_active && !e_done;
      fin      = 1'b0;
      e_pulse  = 1'b0;
      if (e_done) begin
        fin = 1'b0;
      end else if (!m_active) begin
        if (start && !stop) begin
          m_enter(0);
          m_active = 1'b1;
          m_last   = int'(last_step);
          m_loop   = loop && LOOP_EN;
        end
      end else if (stop) begin
        m_active = 1'b0;
        e_func   = IDLE_F;
      end else if (!pause) begin
        m_left--;
        if (m_left == 0) begin
          if (e_idx < m_last) m_enter(e_idx + 1);
          else if (m_loop) m_enter(0);
          else begin
            m_active = 1'b0;
            fin      = 1'b1;
            e_func   = IDLE_F;
          end
        end
      end
      if (was_idle && wr_en) begin
        m_tf[wr_addr] = wr_func;
        m_td[wr_addr] = wr_dwell;
      end
      e_done = fin;
      e_busy = m_active;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("m_func",  32'(func),       32'(e_func));
    check("m_busy",  32'(busy),       32'(e_busy));
    check("m_done",  32'(done),       32'(e_done));
    check("m_pulse", 32'(step_pulse), 32'(e_pulse));
    if (e_busy) check("m_idx", 32'(step_idx), 32'(e_idx));
  endtask

  task automatic write_entry(input int a, input int f, input int d);
    wr_en    = 1'b1;
    wr_addr  = AW'(a);
    wr_func  = 3'(f);
    wr_dwell = DWELL_W'(d);
    cycle();
    wr_en    = 1'b0;
  endtask

  task automatic start_prog(input int last, input bit lp);
    last_step = AW'(last);
    loop      = lp;
    start     = 1'b1;
    cycle();
    start     = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || done) && k < 300) begin
      cycle();
      k++;
    end
    check("wait_idle_timeout", 32'(k < 300), 32'd1);
  endtask

  logic [2:0] exp40 [8];

  initial begin
    int cnt, pulses, dones;
    exp40 = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd5, 3'd5, 3'd0};

    rst = 1'b0;
    cycle();
    cycle();
    check("rst_func",  32'(func),       32'd0);
    check("rst_idx",   32'(step_idx),   32'd0);
    check("rst_pulse", 32'(step_pulse), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_done",  32'(done),       32'd0);
    rst = 1'b1;
    cycle();

    // Freshly reset table: every entry is (000,0), so 8 one-cycle steps.
    start_prog(7, 1'b0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cycle();
      check("rd_func", 32'(func), 32'd0);
      pulses += int'(step_pulse);
    end
    check("rd_pulses", 32'(pulses), 32'd8);
    cycle();
    check("rd_done", 32'(done), 32'd1);
    wait_idle();

    write_entry(0, 1, 3);
    write_entry(1, 2, 0);
    write_entry(2, 5, 1);
    start_prog(2, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cycle();
      check("seq_func", 32'(func), 32'(exp40[k]));
      check("seq_done", 32'(done), 32'(k == 7));
    end
    cycle();
    check("seq_busy_after", 32'(busy), 32'd0);

    start_prog(2, 1'b1);
`ifdef WAVE_SEQ_LOOP_EN
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cycle();
      check("loop_func", 32'(func), 32'(exp40[k % 7]));
      check("loop_done", 32'(done), 32'd0);
    end
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("stop_func", 32'(func), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      dones += int'(done);
    end
    check("stop_no_done", 32'(dones), 32'd0);
`else
    dones = 0;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) cycle();
      if (k < 8) check("oneshot_func", 32'(func), 32'(exp40[k]));
      dones += int'(done);
    end
    check("oneshot_done_cnt", 32'(dones), 32'd1);
    check("oneshot_busy", 32'(busy), 32'd0);
`endif

    write_entry(0, 3, 9);
    start_prog(0, 1'b0);
    cnt = int'(func == 3'd3);
    for (int k = 1; k < 40; k++) begin
      if (k == 3) pause = 1'b1;
      if (k == 8) pause = 1'b0;
      cycle();
      if (func == 3'd3) cnt++;
      else break;
    end
    check("pause_len", 32'(cnt), 32'd15);
    wait_idle();

    start_prog(0, 1'b0);
    cycle();
    write_entry(0, 6, 2);
    wait_idle();
    start_prog(0, 1'b0);
    check("busy_wr_ignored", 32'(func), 32'd3);
    wait_idle();
    write_entry(0, 6, 2);
    start_prog(0, 1'b0);
    check("idle_wr_taken", 32'(func), 32'd6);
    wait_idle();

    write_entry(0, 4, 15);
    start_prog(0, 1'b0);
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (func == 3'd4) cnt++;
      else break;
    end
    check("max_dwell_len", 32'(cnt), 32'd16);
    wait_idle();

    stop  = 1'b1;
    start = 1'b1;
    cycle();
    stop  = 1'b0;
    start = 1'b0;
    check("start_stop_busy",  32'(busy),       32'd0);
    check("start_stop_pulse", 32'(step_pulse), 32'd0);

    start_prog(0, 1'b0);
    pause = 1'b1;
    cycle();
    cycle();
    check("paused_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    cycle();
    stop  = 1'b0;
    pause = 1'b0;
    check("pause_stop_func", 32'(func), 32'd0);
    check("pause_stop_done", 32'(done), 32'd0);

    start_prog(0, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("midrst_func",  32'(func),       32'd0);
    check("midrst_busy",  32'(busy),       32'd0);
    check("midrst_done",  32'(done),       32'd0);
    check("midrst_idx",   32'(step_idx),   32'd0);
    check("midrst_pulse", 32'(step_pulse), 32'd0);
    rst = 1'b1;
    cycle();
    start_prog(0, 1'b0);
    check("midrst_tab_func", 32'(func), 32'd0);
    cycle();
    check("midrst_tab_done", 32'(done), 32'd1);
    wait_idle();

    for (int n = 0; n < 4000; n++) begin
      wr_en     = ($urandom_range(0, 9) < 3);
      wr_addr   = AW'($urandom_range(0, STEPS - 1));
      wr_func   = 3'($urandom_range(0, 6));
      wr_dwell  = ($urandom_range(0, 7) == 0) ? DWELL_W'(15) : DWELL_W'($urandom_range(0, 3));
      last_step = AW'($urandom_range(0, STEPS - 1));
      loop      = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 9) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      pause     = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
